// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder.
// Revision 1.0
`default_nettype none

interface pipelined_adder_if #(
  parameter int N = 16
);
  logic         enable;
  logic         sub;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         Cout;
  logic         V;

  modport master (
    output enable, sub, in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, S, Cout, V
  );

  modport slave (
    input  enable, sub, in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, S, Cout, V
  );
endinterface

`default_nettype wire

// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/subtract with the carry chain cut into STAGES
// registered slices; global stall when the output is held.  Revision 1.0
`default_nettype none

module pipelined_adder #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pipelined_adder_if.slave bus
);
  localparam int W    = N / STAGES;
  localparam int LAST = STAGES - 1;

  logic         w_advance;
  logic         w_accept;

  logic         w_vin [STAGES];
  logic [N-1:0] w_ain [STAGES];
  logic [N-1:0] w_bin [STAGES];
  logic [N-1:0] w_sin [STAGES];
  logic         w_cin [STAGES];

  logic         w_vo  [STAGES];
  logic [N-1:0] w_ao  [STAGES];
  logic [N-1:0] w_bo  [STAGES];
  logic [N-1:0] w_so  [STAGES];
  logic         w_co  [STAGES];

  assign w_advance    = !w_vo[LAST] || bus.out_ready;
  assign bus.in_ready = bus.enable && w_advance;
  assign w_accept     = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W:0]   w_slice;
    logic [N-1:0] w_snext;
    logic         r_vld;
    logic         r_c;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_s;

    // Stage 0 takes operands straight from the port; b is pre-inverted for subtract.
    if (k == 0) begin : g_head
      assign w_vin[k] = w_accept;
      assign w_ain[k] = bus.a;
      assign w_bin[k] = bus.sub ? ~bus.b : bus.b;
      assign w_cin[k] = bus.sub ? 1'b1 : bus.cin;
      assign w_sin[k] = '0;
    end else begin : g_link
      assign w_vin[k] = w_vo[k-1];
      assign w_ain[k] = w_ao[k-1];
      assign w_bin[k] = w_bo[k-1];
      assign w_sin[k] = w_so[k-1];
      assign w_cin[k] = w_co[k-1];
    end

    assign w_slice = {1'b0, w_ain[k][k*W +: W]}
                   + {1'b0, w_bin[k][k*W +: W]}
                   + {{W{1'b0}}, w_cin[k]};

    always_comb begin
      w_snext            = w_sin[k];
      w_snext[k*W +: W]  = w_slice[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_a   <= '0;
        r_b   <= '0;
        r_s   <= '0;
      end else if (w_advance) begin
        r_vld <= w_vin[k];
        r_c   <= w_slice[W];
        r_a   <= w_ain[k];
        r_b   <= w_bin[k];
        r_s   <= w_snext;
      end
    end

    assign w_vo[k] = r_vld;
    assign w_ao[k] = r_a;
    assign w_bo[k] = r_b;
    assign w_so[k] = r_s;
    assign w_co[k] = r_c;
  end

  assign bus.out_valid = w_vo[LAST];
  assign bus.S         = w_so[LAST];
  assign bus.Cout      = w_co[LAST];
  // Signed overflow: operands agree in sign but the result does not.
  assign bus.V         = (w_ao[LAST][N-1] == w_bo[LAST][N-1]) &&
                         (w_so[LAST][N-1] != w_ao[LAST][N-1]);
endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for three adder configurations checked
// against an integer-arithmetic reference model.
`default_nettype none

`define CHECK_PORT(IFX, Q, QC, STG, NAME) \
    if (IFX.out_valid && IFX.out_ready) begin \
      n_tests++; \
      if (Q.size() == 0) begin \
        n_fail++; \
        $display("FAIL %s_unexpected: got result S=%h, required no result", NAME, IFX.S); \
      end else begin \
        exp_r = Q.pop_front(); \
        acc_c = QC.pop_front(); \
        got_r = {IFX.V, IFX.Cout, 32'(IFX.S)}; \
        if (got_r !== exp_r) begin \
          n_fail++; \
          $display("FAIL %s_result: got V/Cout/S=%b/%b/%h, required %b/%b/%h", NAME, got_r[33], got_r[32], got_r[31:0], exp_r[33], exp_r[32], exp_r[31:0]); \
        end \
        if (!rnd_ready) begin \
          n_tests++; \
          if (cyc - acc_c != STG) begin \
            n_fail++; \
            $display("FAIL %s_latency: got %0d, required %0d", NAME, cyc - acc_c, STG); \
          end \
        end \
      end \
    end

module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   pop16   = 0;
  int   sent16  = 0;
  int   s0      = 0;
  int   p0      = 0;
  bit   rnd_ready = 1'b0;
  bit   hold16    = 1'b0;
  logic [17:0] held16;

  logic [33:0] q16[$];
  logic [33:0] q8[$];
  logic [33:0] q32[$];
  int          c16[$];
  int          c8[$];
  int          c32[$];

  pipelined_adder_if #(.N(16)) if16 ();
  pipelined_adder_if #(.N(8))  if8  ();
  pipelined_adder_if #(.N(32)) if32 ();

  pipelined_adder #(.N(16), .STAGES(4)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  pipelined_adder #(.N(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  pipelined_adder #(.N(32), .STAGES(8)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if16.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  // Reference: signed/unsigned integer arithmetic on n-bit values.
  function automatic logic [33:0] model(input int n, input longint unsigned av,
                                        input longint unsigned bv, input logic c, input logic s);
    longint unsigned m, ua, ub, ut, r;
    longint half, sa, sb, st;
    logic co, v;
    m    = (64'd1 << n) - 64'd1;
    ua   = av & m;
    ub   = bv & m;
    half = $signed(64'd1 << (n - 1));
    sa   = ((ua >> (n - 1)) != 0) ? $signed(ua) - 2 * half : $signed(ua);
    sb   = ((ub >> (n - 1)) != 0) ? $signed(ub) - 2 * half : $signed(ub);
    if (s) begin
      st = sa - sb;
      co = (ua >= ub);
      r  = (ua - ub) & m;
    end else begin
      st = sa + sb + longint'(c);
      ut = ua + ub + 64'(c);
      co = (ut > m);
      r  = ut & m;
    end
    v = (st >= half) || (st < -half);
    return {v, co, r[31:0]};
  endfunction

  task automatic send(input bit [2:0] msk, input logic [31:0] av, input logic [31:0] bv,
                      input logic c, input logic s);
    bit [2:0] pend;
    int t;
    @(negedge clk);
    pend = msk;
    if16.a = av[15:0]; if16.b = bv[15:0]; if16.cin = c; if16.sub = s;
    if8.a  = av[7:0];  if8.b  = bv[7:0];  if8.cin  = c; if8.sub  = s;
    if32.a = av;       if32.b = bv;       if32.cin = c; if32.sub = s;
    if16.in_valid = msk[0]; if8.in_valid = msk[1]; if32.in_valid = msk[2];
    for (t = 0; t < 200 && pend != 3'b000; t++) begin
      if (t != 0) begin
        @(negedge clk);
        if16.in_valid = pend[0]; if8.in_valid = pend[1]; if32.in_valid = pend[2];
      end
      #4;
      if (pend[0] && if16.in_ready === 1'b1) begin
        q16.push_back(model(16, 64'(av), 64'(bv), c, s)); c16.push_back(cyc);
        sent16++; pend[0] = 1'b0;
      end
      if (pend[1] && if8.in_ready === 1'b1) begin
        q8.push_back(model(8, 64'(av), 64'(bv), c, s)); c8.push_back(cyc); pend[1] = 1'b0;
      end
      if (pend[2] && if32.in_ready === 1'b1) begin
        q32.push_back(model(32, 64'(av), 64'(bv), c, s)); c32.push_back(cyc); pend[2] = 1'b0;
      end
      @(posedge clk);
    end
    if (pend != 3'b000) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got pending mask %b, required 000", pend);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    if16.in_valid = 1'b0; if8.in_valid = 1'b0; if32.in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    if16.in_valid = 1'b0; if8.in_valid = 1'b0; if32.in_valid = 1'b0;
    for (int t = 0; t < 2000 && (q16.size() + q8.size() + q32.size()) != 0; t++) @(negedge clk);
    if ((q16.size() + q8.size() + q32.size()) != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding, required 0", q16.size() + q8.size() + q32.size());
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    logic [33:0] exp_r;
    logic [33:0] got_r;
    int          acc_c;
    #4;
    if (rst) begin
      hold16 = 1'b0;
    end else begin
      if (hold16) begin
        n_tests++;
        if (!if16.out_valid || {if16.V, if16.Cout, if16.S} !== held16) begin
          n_fail++;
          $display("FAIL dut16_hold: got valid=%b V/Cout/S=%h, required valid=1 V/Cout/S=%h",
                   if16.out_valid, {if16.V, if16.Cout, if16.S}, held16);
        end
      end
      n_tests++;
      if (if16.in_ready !== (if16.enable && (!if16.out_valid || if16.out_ready))) begin
        n_fail++;
        $display("FAIL dut16_in_ready: got %b, required %b", if16.in_ready,
                 if16.enable && (!if16.out_valid || if16.out_ready));
      end
      if (if16.out_valid && if16.out_ready) pop16++;
      `CHECK_PORT(if16, q16, c16, 4, "dut16")
      `CHECK_PORT(if8,  q8,  c8,  1, "dut8")
      `CHECK_PORT(if32, q32, c32, 8, "dut32")
      hold16 = if16.out_valid && !if16.out_ready;
      held16 = {if16.V, if16.Cout, if16.S};
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    if16.enable = 1'b1; if8.enable = 1'b1; if32.enable = 1'b1;
    if16.in_valid = 1'b0; if8.in_valid = 1'b0; if32.in_valid = 1'b0;
    if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0;
    if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0; if8.sub  = 1'b0;
    if32.a = '0; if32.b = '0; if32.cin = 1'b0; if32.sub = 1'b0;
    if8.out_ready = 1'b1; if32.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({if16.out_valid, if16.V, if16.Cout, if16.S} !== 19'd0) begin
      n_fail++; $display("FAIL reset16: got %h, required 0", {if16.out_valid, if16.V, if16.Cout, if16.S});
    end
    n_tests++;
    if ({if8.out_valid, if8.V, if8.Cout, if8.S} !== 11'd0) begin
      n_fail++; $display("FAIL reset8: got %h, required 0", {if8.out_valid, if8.V, if8.Cout, if8.S});
    end
    n_tests++;
    if ({if32.out_valid, if32.V, if32.Cout, if32.S} !== 35'd0) begin
      n_fail++; $display("FAIL reset32: got %h, required 0", {if32.out_valid, if32.V, if32.Cout, if32.S});
    end
    n_tests++;
    if (if16.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, required 1", if16.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed boundaries on all three configurations.
    send(3'b111, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    send(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(3'b111, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    send(3'b111, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(3'b111, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    send(3'b111, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(3'b111, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    send(3'b111, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
    send(3'b111, 32'h0000_8000, 32'h0000_0001, 1'b1, 1'b1);
    send(3'b111, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(3'b111, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1);
    drain();

    // Random operands with backpressure on the 16-bit pipe and input gaps.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(3'b111, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Stream with a mid-run enable drop.
    s0 = sent16;
    p0 = pop16;
    fork
      begin
        for (int i = 0; i < 256; i++) send(3'b001, 32'(i), 32'd1, 1'b0, 1'b0);
      end
      begin
        wait (sent16 >= s0 + 100);
        @(negedge clk);
        if16.enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #4;
          n_tests++;
          if (if16.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL enable_low_in_ready: got %b, required 0", if16.in_ready);
          end
          @(negedge clk);
        end
        if16.enable = 1'b1;
      end
    join
    drain();
    n_tests++;
    if (pop16 - p0 != 256) begin
      n_fail++; $display("FAIL stream_count: got %0d, required 256", pop16 - p0);
    end

    // Reset with results in flight.
    rnd_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) send(3'b001, 32'h100 + 32'(i), 32'h10, 1'b0, 1'b0);
    @(negedge clk);
    if16.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (if16.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_valid: got %b, required 0", if16.out_valid);
    end
    n_tests++;
    if ({if16.V, if16.Cout, if16.S} !== 18'd0) begin
      n_fail++; $display("FAIL midreset_data: got %h, required 0", {if16.V, if16.Cout, if16.S});
    end
    q16.delete();
    c16.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send(3'b001, 32'h0F0F, 32'h00F1, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`undef CHECK_PORT
`default_nettype wire

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit adder/subtractor with valid/ready handshakes on input and output. It is the sequential successor of the combinational behavioural adder. The carry chain is split into STAGES equal slices, with one register stage per slice, so wide operands close timing at one result per clock. It sits between operand sources, such as register-file read ports or a streaming front end, and any consumer that can apply backpressure.

## Interface
- N, default 16: operand and sum width; must be divisible by STAGES.
- STAGES, default 4: pipeline depth and slice count; range 1..N. Slice width W = N/STAGES.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when 0, no new operands are accepted; in-flight results still drain.
- sub  input  1  0 = add (a + b + cin); 1 = subtract (a + ~b + 1), with cin ignored.
- in_valid  input  1  operands on a, b, cin, sub are valid.
- in_ready  output  1  block will accept operands this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in; used in add mode only.
- out_valid  output  1  S, Cout, V hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- S  output  N  sum or difference.
- Cout  output  1  carry out of bit N-1. In sub mode, 1 = no borrow.
- V  output  1  signed (two's-complement) overflow.

## Operation
- advance = !out_valid || out_ready. This is a global stall: when low, no pipeline register changes.
- in_ready = enable && advance. This is combinational, with no dependency on in_valid.
- accept = in_valid && in_ready. On accept, stage 0 captures the operands; b is inverted when sub=1.
- Carry-in to stage 0:
  - cin when sub=0.
  - 1 when sub=1.
- On advance without accept, stage 0 loads a bubble: valid=0, data don't-care.
- Stage k (0..STAGES-1):
  - Adds slice bits [k*W +: W] of the held operands plus the registered carry from stage k-1 (or the stage 0 carry-in).
  - Registers the W-bit partial sum and the carry out of the slice.
  - Carries forward the unprocessed upper operand slices and all lower sum slices.
- Each stage holds a valid bit, which shifts forward on advance.
- Last stage drives the outputs:
  - S: the full N-bit concatenation.
  - Cout: the final slice carry.
  - V = (a[N-1] == b'[N-1]) && (S[N-1] != a[N-1]), where b' is the possibly inverted b. a[N-1] and b'[N-1] are carried to the last stage for this.
- Results leave in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
- Width rule: S wraps modulo 2^N; the true carry appears only on Cout.
- enable=0 mid-stream: in_ready=0 and bubbles enter. Valid results already in flight still reach the output and wait for out_ready.
- STAGES=1: single register stage, functionally a registered adder.

## Timing
- Latency: an operand accepted at rising edge t presents out_valid=1 with its result after edge t+STAGES, provided there is no stall in between. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1 and in_valid=1.
- Simultaneous out_valid=1, out_ready=1, in_valid=1: the output is consumed and a new operand is accepted on the same edge.
- out_valid=1, out_ready=0:
  - in_ready=0.
  - S, Cout, V are held stable until the handshake completes.
- Reset (asynchronous assert, at any time, including mid-stream):
  - All stage valid bits clear; out_valid=0.
  - S=0, Cout=0, V=0; all data and carry registers clear.
  - in_ready follows enable, since advance=1 after reset.
  - In-flight results are discarded.
- After reset deassertion, the first acceptance can occur on the first rising edge.

## Test plan
- N=16, STAGES=4, add: a=0x00FF, b=0x0001, cin=0 accepted at edge t -> out_valid at t+4 with S=0x0100, Cout=0, V=0.
- Add boundaries: 0xFFFF+0x0001, cin=0 -> S=0x0000, Cout=1, V=0. 0x7FFF+0x0001 -> S=0x8000, Cout=0, V=1. 0x0000+0x0000, cin=1 -> S=0x0001.
- Subtract: sub=1, a=0x0005, b=0x0007 -> S=0xFFFE, Cout=0, V=0. a=0x8000, b=0x0001 -> S=0x7FFF, Cout=1, V=1. cin=1 must not change either result.
- Stream a=i, b=0x0001, i=0..255, in_valid held high, out_ready pseudo-random, enable dropped for 5 cycles mid-run -> exactly 256 results S=i+1 in order. Outputs stay stable whenever out_valid=1 and out_ready=0. in_ready=0 throughout the enable-low window.
- Assert rst for one cycle with 3 results in flight -> out_valid=0 and S=0 immediately. No stale result ever appears. The next accepted operand returns after exactly 4 cycles.
- Rerun the first two scenarios with N=8, STAGES=1 (latency 1) and N=32, STAGES=8 (latency 8): same arithmetic results, 0xFFFFFFFF+1 -> S=0, Cout=1.
